// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//    Shares one 32-bit integer ALU between two requesters. Port 0 is the
//    execute stage and port 1 is the address-generation/branch unit.
//    Requests are arbitrated round-robin with valid/ready handshakes. The
//    ALU output is registered into a one-entry response buffer that honours
//    consumer backpressure. Per-requester saturating counters record how
//    many operations each port has had accepted.
//
// Ports:
//    clk          clock, all state updates on the rising edge
//    rst_n        synchronous active-low reset
//    reqN_valid   requester N presents an operation
//    reqN_ready   requester N operation accepted when valid & ready
//    reqN_a/b     operands from requester N
//    reqN_op      ALU opcode from requester N
//    rsp_valid    response buffer holds a result
//    rsp_ready    consumer takes the response when valid & ready
//    rsp_result   buffered ALU result
//    rsp_zero     buffered zero flag (result == 0)
//    rsp_id       requester that issued the buffered result
//    grant_cntN   accepted operations from requester N, saturating
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// alu
//
// Purpose:
//    Purely combinational 32-bit integer ALU.
//
// Ports:
//    a_i, b_i     operands
//    op_i         0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor,
//                 0110 shift-left-logical by b_i[4:0]; any other code gives 0
//    result_o     operation result
//    zero_o       high when result_o is zero
// ---------------------------------------------------------------------------
module alu (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [3:0]  op_i,
   output logic [31:0] result_o,
   output logic        zero_o
);

   // Opcode decode; unsupported codes fall through to a zero result so the
   // caller still gets a well-defined value and a set zero flag.
   always_comb begin
      result_o = 32'd0;
      unique case (op_i)
         4'b0000: result_o = a_i + b_i;
         4'b0001: result_o = a_i - b_i;
         4'b0010: result_o = a_i & b_i;
         4'b0011: result_o = a_i | b_i;
         4'b0100: result_o = a_i ^ b_i;
         4'b0110: result_o = a_i << b_i[4:0];
         default: result_o = 32'd0;
      endcase
   end

   assign zero_o = (result_o == 32'd0);

endmodule

module alu_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [3:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [3:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_zero,
   output logic             rsp_id,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
);

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic             rspValid_q, rspValid_d;
   logic [31:0]      rspResult_q, rspResult_d;
   logic             rspZero_q, rspZero_d;
   logic             rspId_q, rspId_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   logic             canAccept;
   logic             grant0, grant1;
   logic             fire0, fire1;
   logic [31:0]      aluA, aluB, aluResult;
   logic [3:0]       aluOp;
   logic             aluZero;

   // The buffer can take a new result when it is empty or being drained in
   // this same cycle, which gives full throughput with no bubble.
   assign canAccept = ~rspValid_q | rsp_ready;

   // Round-robin: on a tie the requester that did not win last time gets
   // the grant. last_q resets to 1 so requester 0 wins the first tie.
   assign grant0 = req0_valid & (~req1_valid |  last_q);
   assign grant1 = req1_valid & (~req0_valid | ~last_q);

   assign req0_ready = grant0 & canAccept;
   assign req1_ready = grant1 & canAccept;

   assign fire0 = req0_valid & req0_ready;
   assign fire1 = req1_valid & req1_ready;

   // The granted port steers the shared ALU inputs.
   assign aluA  = grant1 ? req1_a  : req0_a;
   assign aluB  = grant1 ? req1_b  : req0_b;
   assign aluOp = grant1 ? req1_op : req0_op;

   alu u_alu (
      .a_i      (aluA),
      .b_i      (aluB),
      .op_i     (aluOp),
      .result_o (aluResult),
      .zero_o   (aluZero)
   );

   // Next-state for the response buffer, round-robin pointer and counters.
   // The pointer moves only on an accepted transfer, so a grant that is
   // stalled by backpressure does not cost the other requester its turn.
   always_comb begin
      rspValid_d  = rspValid_q;
      rspResult_d = rspResult_q;
      rspZero_d   = rspZero_q;
      rspId_d     = rspId_q;
      last_d      = last_q;
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;

      if (fire0 | fire1) begin
         rspValid_d  = 1'b1;
         rspResult_d = aluResult;
         rspZero_d   = aluZero;
         rspId_d     = fire1;
         last_d      = fire1;
      end else if (rsp_ready) begin
         rspValid_d  = 1'b0;
      end

      if (fire0 && (cnt0_q != CntMax)) begin
         cnt0_d = cnt0_q + CntOne;
      end
      if (fire1 && (cnt1_q != CntMax)) begin
         cnt1_d = cnt1_q + CntOne;
      end
   end

   // State registers with synchronous active-low reset; a reset discards
   // any buffered response without a handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rspValid_q  <= 1'b0;
         rspResult_q <= 32'd0;
         rspZero_q   <= 1'b0;
         rspId_q     <= 1'b0;
         last_q      <= 1'b1;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else begin
         rspValid_q  <= rspValid_d;
         rspResult_q <= rspResult_d;
         rspZero_q   <= rspZero_d;
         rspId_q     <= rspId_d;
         last_q      <= last_d;
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
      end
   end

   assign rsp_valid  = rspValid_q;
   assign rsp_result = rspResult_q;
   assign rsp_zero   = rspZero_q;
   assign rsp_id     = rspId_q;
   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Purpose:
//    Directed self-checking bench for alu_arbiter, built with 4-bit grant
//    counters so that saturation is reachable in a short run. Inputs are
//    driven 1 time unit after the rising edge and outputs are sampled a
//    further unit later, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int CW = 4;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0110;
   localparam logic [3:0] OP_BAD = 4'b0111;

   logic          clk;
   logic          rst_n;
   logic          req0_valid, req0_ready;
   logic [31:0]   req0_a, req0_b;
   logic [3:0]    req0_op;
   logic          req1_valid, req1_ready;
   logic [31:0]   req1_a, req1_b;
   logic [3:0]    req1_op;
   logic          rsp_valid, rsp_ready;
   logic [31:0]   rsp_result;
   logic          rsp_zero, rsp_id;
   logic [CW-1:0] grant_cnt0, grant_cnt1;

   int nAssert = 0;
   int nFail   = 0;

   alu_arbiter #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_id     (rsp_id),
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = OP_ADD;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = OP_ADD;
      rsp_ready  = 1'b0;
      doReset();
      #1;
      nAssert++; if (rsp_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid got %0b want 0", rsp_valid); end
      nAssert++; if (rsp_result !== 32'd0) begin nFail++; $display("[TB] FAIL reset_result got %0h want 0", rsp_result); end
      nAssert++; if (rsp_zero !== 1'b0) begin nFail++; $display("[TB] FAIL reset_zero got %0b want 0", rsp_zero); end
      nAssert++; if (rsp_id !== 1'b0) begin nFail++; $display("[TB] FAIL reset_id got %0b want 0", rsp_id); end
      nAssert++; if (grant_cnt0 !== 4'd0) begin nFail++; $display("[TB] FAIL reset_cnt0 got %0d want 0", grant_cnt0); end
      nAssert++; if (grant_cnt1 !== 4'd0) begin nFail++; $display("[TB] FAIL reset_cnt1 got %0d want 0", grant_cnt1); end
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = OP_ADD;
      #1;
      nAssert++; if (req0_ready !== 1'b1) begin nFail++; $display("[TB] FAIL single_ready0 got %0b want 1", req0_ready); end
      nAssert++; if (req1_ready !== 1'b0) begin nFail++; $display("[TB] FAIL single_ready1 got %0b want 0", req1_ready); end
      tick();
      req0_valid = 1'b0;
      #1;
      nAssert++; if (rsp_valid !== 1'b1) begin nFail++; $display("[TB] FAIL single_valid got %0b want 1", rsp_valid); end
      nAssert++; if (rsp_result !== 32'd12) begin nFail++; $display("[TB] FAIL single_result got %0d want 12", rsp_result); end
      nAssert++; if (rsp_zero !== 1'b0) begin nFail++; $display("[TB] FAIL single_zero got %0b want 0", rsp_zero); end
      nAssert++; if (rsp_id !== 1'b0) begin nFail++; $display("[TB] FAIL single_id got %0b want 0", rsp_id); end
      nAssert++; if (grant_cnt0 !== 4'd1) begin nFail++; $display("[TB] FAIL single_cnt0 got %0d want 1", grant_cnt0); end
   endtask

   // Both ports held valid for 8 cycles: ids alternate starting with 0.
   task automatic test_tie();
      logic        expId;
      logic [31:0] expRes;
      doReset();
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd9;    req0_b = 32'd9;    req0_op = OP_SUB;
      req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_op = OP_OR;
      for (int i = 0; i < 8; i++) begin
         tick();
         #1;
         expId  = i[0];
         expRes = expId ? 32'hFF : 32'h0;
         nAssert++; if (rsp_valid !== 1'b1) begin nFail++; $display("[TB] FAIL tie_valid[%0d] got %0b want 1", i, rsp_valid); end
         nAssert++; if (rsp_id !== expId) begin nFail++; $display("[TB] FAIL tie_id[%0d] got %0b want %0b", i, rsp_id, expId); end
         nAssert++; if (rsp_result !== expRes) begin nFail++; $display("[TB] FAIL tie_result[%0d] got %0h want %0h", i, rsp_result, expRes); end
         nAssert++; if (rsp_zero !== ~expId) begin nFail++; $display("[TB] FAIL tie_zero[%0d] got %0b want %0b", i, rsp_zero, ~expId); end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      nAssert++; if (grant_cnt0 !== 4'd4) begin nFail++; $display("[TB] FAIL tie_cnt0 got %0d want 4", grant_cnt0); end
      nAssert++; if (grant_cnt1 !== 4'd4) begin nFail++; $display("[TB] FAIL tie_cnt1 got %0d want 4", grant_cnt1); end
   endtask

   // Buffer 0x10 from req0 (last becomes 0), then stall with both valid;
   // on release req1 must be granted since last did not move while stalled.
   task automatic test_backpressure();
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_a = 32'h8; req0_b = 32'h8; req0_op = OP_ADD;
      tick();
      rsp_ready  = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = OP_ADD;
      for (int i = 0; i < 5; i++) begin
         #1;
         nAssert++; if (req0_ready !== 1'b0) begin nFail++; $display("[TB] FAIL bp_ready0[%0d] got %0b want 0", i, req0_ready); end
         nAssert++; if (req1_ready !== 1'b0) begin nFail++; $display("[TB] FAIL bp_ready1[%0d] got %0b want 0", i, req1_ready); end
         nAssert++; if (rsp_valid !== 1'b1) begin nFail++; $display("[TB] FAIL bp_valid[%0d] got %0b want 1", i, rsp_valid); end
         nAssert++; if (rsp_result !== 32'h10) begin nFail++; $display("[TB] FAIL bp_result[%0d] got %0h want 10", i, rsp_result); end
         nAssert++; if (rsp_id !== 1'b0) begin nFail++; $display("[TB] FAIL bp_id[%0d] got %0b want 0", i, rsp_id); end
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      nAssert++; if (req1_ready !== 1'b1) begin nFail++; $display("[TB] FAIL bp_release_ready1 got %0b want 1", req1_ready); end
      nAssert++; if (req0_ready !== 1'b0) begin nFail++; $display("[TB] FAIL bp_release_ready0 got %0b want 0", req0_ready); end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      nAssert++; if (rsp_valid !== 1'b1) begin nFail++; $display("[TB] FAIL bp_nobubble_valid got %0b want 1", rsp_valid); end
      nAssert++; if (rsp_id !== 1'b1) begin nFail++; $display("[TB] FAIL bp_nobubble_id got %0b want 1", rsp_id); end
      nAssert++; if (rsp_result !== 32'd7) begin nFail++; $display("[TB] FAIL bp_nobubble_result got %0d want 7", rsp_result); end
   endtask

   task automatic test_drain();
      rsp_ready = 1'b1;
      tick();
      #1;
      nAssert++; if (rsp_valid !== 1'b0) begin nFail++; $display("[TB] FAIL drain_valid got %0b want 0", rsp_valid); end
   endtask

   // Counts carried from the tie and backpressure tests: cnt0=5, cnt1=5.
   task automatic test_shift_unsupported();
      rsp_ready  = 1'b1;
      req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'h25; req1_op = OP_SLL;
      tick();
      req1_valid = 1'b0;
      #1;
      nAssert++; if (rsp_result !== 32'h20) begin nFail++; $display("[TB] FAIL sll_result got %0h want 20", rsp_result); end
      nAssert++; if (rsp_id !== 1'b1) begin nFail++; $display("[TB] FAIL sll_id got %0b want 1", rsp_id); end
      nAssert++; if (rsp_zero !== 1'b0) begin nFail++; $display("[TB] FAIL sll_zero got %0b want 0", rsp_zero); end
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = OP_BAD;
      tick();
      req0_valid = 1'b0;
      #1;
      nAssert++; if (rsp_result !== 32'd0) begin nFail++; $display("[TB] FAIL badop_result got %0h want 0", rsp_result); end
      nAssert++; if (rsp_zero !== 1'b1) begin nFail++; $display("[TB] FAIL badop_zero got %0b want 1", rsp_zero); end
      nAssert++; if (rsp_id !== 1'b0) begin nFail++; $display("[TB] FAIL badop_id got %0b want 0", rsp_id); end
      nAssert++; if (grant_cnt0 !== 4'd6) begin nFail++; $display("[TB] FAIL badop_cnt0 got %0d want 6", grant_cnt0); end
      nAssert++; if (grant_cnt1 !== 4'd6) begin nFail++; $display("[TB] FAIL badop_cnt1 got %0d want 6", grant_cnt1); end
   endtask

   task automatic test_saturation();
      logic [CW-1:0] expCnt;
      doReset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         req0_valid = 1'b1; req0_a = i; req0_b = 32'd1; req0_op = OP_ADD;
         tick();
         #1;
         expCnt = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
         nAssert++; if (grant_cnt0 !== expCnt) begin nFail++; $display("[TB] FAIL sat_cnt0[%0d] got %0d want %0d", i, grant_cnt0, expCnt); end
         nAssert++; if (rsp_result !== 32'(i + 1)) begin nFail++; $display("[TB] FAIL sat_result[%0d] got %0d want %0d", i, rsp_result, i + 1); end
      end
      req0_valid = 1'b0;
   endtask

   task automatic test_reset_midop();
      rsp_ready = 1'b0;
      #1;
      nAssert++; if (rsp_valid !== 1'b1) begin nFail++; $display("[TB] FAIL midop_pre_valid got %0b want 1", rsp_valid); end
      rst_n = 1'b0;
      tick();
      #1;
      nAssert++; if (rsp_valid !== 1'b0) begin nFail++; $display("[TB] FAIL midop_valid got %0b want 0", rsp_valid); end
      nAssert++; if (grant_cnt0 !== 4'd0) begin nFail++; $display("[TB] FAIL midop_cnt0 got %0d want 0", grant_cnt0); end
      nAssert++; if (grant_cnt1 !== 4'd0) begin nFail++; $display("[TB] FAIL midop_cnt1 got %0d want 0", grant_cnt1); end
      rst_n      = 1'b1;
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = OP_ADD;
      req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = OP_ADD;
      #1;
      nAssert++; if (req0_ready !== 1'b1) begin nFail++; $display("[TB] FAIL midop_tie_ready0 got %0b want 1", req0_ready); end
      nAssert++; if (req1_ready !== 1'b0) begin nFail++; $display("[TB] FAIL midop_tie_ready1 got %0b want 0", req1_ready); end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      nAssert++; if (rsp_id !== 1'b0) begin nFail++; $display("[TB] FAIL midop_tie_id got %0b want 0", rsp_id); end
      nAssert++; if (rsp_result !== 32'd4) begin nFail++; $display("[TB] FAIL midop_tie_result got %0d want 4", rsp_result); end
   endtask

   // Scenario sequence; every step advances a fixed number of cycles.
   initial begin
      rst_n = 1'b0;
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_drain();
      test_shift_unsupported();
      test_saturation();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit integer ALU between two requesters: port 0 is the execute stage and port 1 is the address-generation/branch unit.
- Arbitration is round-robin with valid/ready handshakes on both request ports.
- The ALU output is registered into a one-entry response buffer with backpressure.
- Contains one instance of the existing alu; the arbiter adds no arithmetic of its own.

Parameters:
- CNT_W, 16, width of the per-requester grant counters (saturating).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
- req0_a  input  32  operand A, requester 0
- req0_b  input  32  operand B, requester 0
- req0_op  input  4  ALU op, requester 0 (0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0110 sll by b[4:0]; others yield 0)
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as above, requester 1
- rsp_valid  output  1  response buffer holds a result
- rsp_ready  input  1  consumer takes the response when valid&ready
- rsp_result  output  32  registered ALU result
- rsp_zero  output  1  registered ALU zero flag (result == 0)
- rsp_id  output  1  requester that issued this result
- grant_cnt0  output  CNT_W  accepted ops from requester 0, saturating at all-ones
- grant_cnt1  output  CNT_W  accepted ops from requester 1, saturating at all-ones

Behaviour:
- Reset (rst_n low at a clock edge):
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0.
  - grant_cnt0 and grant_cnt1 = 0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
- Reset mid-operation: a buffered response is discarded with no handshake, and counters clear. The req*_ready outputs are combinational and are not gated by rst_n.
- Buffer capacity:
  - can_accept = ~rsp_valid | rsp_ready, i.e. the buffer is empty or drains this cycle.
- Grant, combinational:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester != last.
  - Neither valid: no grant.
- Ready: reqN_ready = grantN & can_accept. At most one ready is high per cycle. Ready may depend combinationally on either valid; requesters must not make valid depend on ready.
- Accept: a transfer occurs when reqN_valid & reqN_ready. The operands and op of the granted port drive the ALU. At the clock edge:
  - rsp_result and rsp_zero capture the ALU outputs.
  - rsp_id=N, rsp_valid=1.
  - last=N.
  - grant_cntN increments unless already all-ones.
- Latency and throughput:
  - Latency is 1 cycle: rsp_valid rises on the edge that accepts the request.
  - With rsp_ready held high, throughput is 1 op/cycle.
- Drain without accept: if rsp_valid & rsp_ready and no transfer occurs, rsp_valid falls to 0 at the edge.
- Simultaneous drain and accept: the buffer is overwritten with the new result and rsp_valid stays 1. No bubble.
- Backpressure: while rsp_valid & ~rsp_ready, rsp_result, rsp_zero and rsp_id hold stable and both req*_ready are 0.
- Pointer update: last changes only on an accepted transfer. A grant that is not accepted (can_accept=0) leaves last unchanged, so fairness is preserved across stalls.
- Starvation: with both ports continuously valid and no stalls, grants strictly alternate 0,1,0,1...
- Unsupported op: the ALU returns 0, so rsp_zero=1. The op is still accepted and counted; no error signalling.

Test Plan:
- Reset then single op: rst_n low 2 cycles, then req0 add a=5 b=7 -> req0_ready=1 the same cycle; next cycle rsp_valid=1, rsp_result=12, rsp_zero=0, rsp_id=0, grant_cnt0=1.
- Tie after reset: both valid (req0 sub 9-9, req1 or 0xF0|0x0F), rsp_ready=1 -> first rsp_id=0 with result 0 and rsp_zero=1; next rsp_id=1 with result 0xFF; with both held valid, ids alternate 0,1,0,1 for 8 cycles and each counter reaches 4.
- Backpressure: rsp_ready=0 with a buffered result 0x10 while req1 is valid -> both readys 0 for 5 cycles, rsp_result stays 0x10, last unchanged. Raise rsp_ready -> req1 accepted the same cycle as the drain, no bubble.
- Drain to empty: a single response with rsp_ready=1 and no requests -> rsp_valid falls after one cycle.
- Shift and unsupported op: req1 sll a=1 b=0x25 -> result 0x20 (shift amount 5). req0 op 0111 -> result 0, rsp_zero=1, grant_cnt0 increments.
- Saturation and reset mid-op: CNT_W=4, 20 req0 ops -> grant_cnt0=15 and holds. Then assert rst_n low while rsp_valid=1 -> rsp_valid=0, both counters 0, and the next tie is won by requester 0.
